// File: rtl/shift_reg_ec_if.sv
`default_nettype none
// ============================================================================
// Module  : shift_reg_ec_if
// Brief   : Control, data and status bundle for the shift_reg_ec register.
// Revision: 1.0 - initial release
// ============================================================================
interface shift_reg_ec_if #(
    parameter int WIDTH = 8
);
    logic             Clr;
    logic             En;
    logic [1:0]       Mode;
    logic             Rot;
    logic [WIDTH-1:0] D;
    logic             SinR;
    logic             SinL;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;
    logic             SoutR;
    logic             SoutL;
    logic             Done;

    modport master (
        output Clr, En, Mode, Rot, D, SinR, SinL,
        input  Q, Qn, SoutR, SoutL, Done
    );

    modport slave (
        input  Clr, En, Mode, Rot, D, SinR, SinL,
        output Q, Qn, SoutR, SoutL, Done
    );
endinterface
`default_nettype wire

// File: rtl/shift_reg_ec.sv
`default_nettype none
// ============================================================================
// Module  : shift_reg_ec
// Brief   : Bidirectional shift/rotate/load register with shift counter and
//           one-shot Done after WIDTH shifts since the last load or clear.
// Revision: 1.0 - initial release
// ============================================================================
module shift_reg_ec #(
    parameter int          WIDTH   = 8,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  wire logic       Clk,
    input  wire logic       Rst,
    shift_reg_ec_if.slave   bus
);
    localparam int               c_CNT_W  = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_RST_Q  = RST_VAL[WIDTH-1:0];

    localparam logic [1:0] c_MODE_HOLD = 2'b00;
    localparam logic [1:0] c_MODE_SHR  = 2'b01;
    localparam logic [1:0] c_MODE_SHL  = 2'b10;
    localparam logic [1:0] c_MODE_LOAD = 2'b11;

    logic [WIDTH-1:0]   data_q, data_d;
    logic [c_CNT_W-1:0] cnt_q,  cnt_d;
    logic               done_q, done_d;
    logic               w_shift;

    assign w_shift = bus.En && ((bus.Mode == c_MODE_SHR) || (bus.Mode == c_MODE_SHL));

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (bus.Clr) begin
            data_d = c_RST_Q;
            cnt_d  = '0;
        end else if (bus.En) begin
            case (bus.Mode)
                c_MODE_SHR:  data_d = {(bus.Rot ? data_q[0] : bus.SinR), data_q[WIDTH-1:1]};
                c_MODE_SHL:  data_d = {data_q[WIDTH-2:0], (bus.Rot ? data_q[WIDTH-1] : bus.SinL)};
                c_MODE_LOAD: begin
                    data_d = bus.D;
                    cnt_d  = '0;
                end
                c_MODE_HOLD: data_d = data_q;
                default:     data_d = data_q;
            endcase
            // Counter saturates, so Done fires only on the WIDTH-1 -> WIDTH step.
            if (w_shift) begin
                done_d = (cnt_q == c_CNT_LAST);
                if (cnt_q != c_CNT_FULL) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            data_q <= c_RST_Q;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bus.Q     = data_q;
    assign bus.Qn    = ~data_q;
    assign bus.SoutR = data_q[0];
    assign bus.SoutL = data_q[WIDTH-1];
    assign bus.Done  = done_q;
endmodule
`default_nettype wire

// File: doc/shift_reg_ec.md
SHIFT_REG_EC -- requirements
Module: shift_reg_ec

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the register width in bits, with a legal range of 2..32.
REQ-002 Parameter RST_VAL, default 0 (WIDTH bits), SHALL set the value Q takes on reset or clear.
REQ-003 Port Clk, input, 1, SHALL be the single clock; all state SHALL update on the rising edge only.
REQ-004 Port Rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-005 Port Clr, input, 1, SHALL be a synchronous active-high clear of the data register, with lower priority than Rst.
REQ-006 Port En, input, 1, SHALL be the clock enable; when En is 0, Q and the shift counter hold.
REQ-007 Port Mode, input, 2, SHALL select the operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-008 Port Rot, input, 1, SHALL make a shift recirculate the bit shifted out instead of taking the serial input.
REQ-009 Port D, input, WIDTH, SHALL be the parallel load data.
REQ-010 Port SinR, input, 1, SHALL be the serial input entering at the MSB on a right shift.
REQ-011 Port SinL, input, 1, SHALL be the serial input entering at the LSB on a left shift.
REQ-012 Port Q, output, WIDTH, SHALL be the registered data.
REQ-013 Port Qn, output, WIDTH, SHALL be the bitwise complement of Q.
REQ-014 Port SoutR, output, 1, SHALL equal Q[0].
REQ-015 Port SoutL, output, 1, SHALL equal Q[WIDTH-1].
REQ-016 Port Done, output, 1, SHALL be a registered one-cycle pulse marking WIDTH shifts completed since the last load.

Function
REQ-017 Operations SHALL have this priority per edge: Rst > Clr > (En=0 hold) > Mode.
REQ-018 Clr=1 SHALL set Q to RST_VAL and Cnt to 0, and SHALL drive Done to 0 on the next cycle, regardless of En.
REQ-019 Shift right SHALL produce Q <= {Rot ? Q[0] : SinR, Q[WIDTH-1:1]}.
REQ-020 Shift left SHALL produce Q <= {Q[WIDTH-2:0], Rot ? Q[WIDTH-1] : SinL}.
REQ-021 Load (Mode=11) SHALL produce Q <= D and Cnt <= 0; Rot SHALL be ignored.
REQ-022 Hold (Mode=00) with En=1 SHALL leave Q and Cnt unchanged.
REQ-023 Internal counter Cnt, width clog2(WIDTH+1), SHALL increment on each enabled shift (Mode 01 or 10) while Cnt < WIDTH.
REQ-024 Cnt SHALL saturate at WIDTH; further shifts SHALL change Q but not Cnt.
REQ-025 Done SHALL be 1 for exactly the cycle after the edge on which Cnt goes from WIDTH-1 to WIDTH, and 0 otherwise.
REQ-026 Done SHALL NOT pulse again until a load or clear re-arms Cnt.
REQ-027 A mode change mid-sequence (left to right) SHALL count both directions toward the same Cnt.
REQ-028 Latency: Q, Cnt and Done SHALL reflect an operation one clock after the sampling edge; Qn, SoutR and SoutL SHALL be combinational from Q.
REQ-029 Inputs SHALL be sampled only on the rising Clk edge; there SHALL be no asynchronous paths.

Reset
REQ-030 With Rst=1 at a rising edge, Q SHALL become RST_VAL, Qn ~RST_VAL, Cnt 0 and Done 0, overriding Clr, En and Mode.
REQ-031 Reset asserted mid-shift-sequence SHALL discard the partial count; after release, a full WIDTH shifts SHALL be needed before Done.
REQ-032 Before the first reset edge, outputs are undefined; the bench SHALL NOT check them.

Verification (WIDTH=8, RST_VAL=0 unless noted)
REQ-033 Rst=1 for one edge, then En=0 for 3 edges -> Q=8'h00, Qn=8'hFF, Done=0 throughout.
REQ-034 Load D=8'hA5, then 8 right shifts with SinR=0, Rot=0 -> Q sequence 52,29,14,0A,05,02,01,00; Done=1 only in the cycle after the 8th shift.
REQ-035 Load 8'h81, Rot=1, 8 left shifts -> Q returns to 8'h81; Done pulses once; a 9th shift gives Q=8'h03 and no Done.
REQ-036 Load 8'hF0, 4 shifts, then Clr=1 together with Mode=11, D=8'hFF -> Q=8'h00 (Clr wins); 8 further shifts needed for Done.
REQ-037 Load 8'h3C, En=0 with Mode=01 for 5 edges -> Q stays 8'h3C and Cnt unchanged; Rst=1 during a sequence with Cnt=5 -> Q=8'h00, and 8 new shifts are needed for Done.
REQ-038 RST_VAL=8'h5A, WIDTH=4 instance: reset -> Q=4'hA; 4 left shifts with SinL=1 -> Q=4'hF, Done pulses once.
